// File: rtl/cpu65_pkg.sv
// cpu65_pkg: shared vectors, reset-stretcher state type and parameter limits for the 6502 bus controller
package cpu65_pkg;

  // 6502 hardware vector low-byte addresses
  localparam logic [15:0] NMI_VEC_LO = 16'hFFFA;
  localparam logic [15:0] RES_VEC_LO = 16'hFFFC;
  localparam logic [15:0] IRQ_VEC_LO = 16'hFFFE;

  // Legal parameter ranges
  localparam int ADDR_W_MIN       = 1;
  localparam int ADDR_W_MAX       = 16;
  localparam int CLK_DIV_MIN      = 2;
  localparam int CLK_DIV_MAX      = 15;
  localparam int RESET_CYCLES_MIN = 1;
  localparam int RESET_CYCLES_MAX = 255;

  typedef enum logic {RST_HOLD, RST_RUN} rst_state_t;

  function automatic bit params_ok(int addr_w, int clk_div, int reset_cycles);
    return (addr_w >= ADDR_W_MIN) && (addr_w <= ADDR_W_MAX) &&
           (clk_div >= CLK_DIV_MIN) && (clk_div <= CLK_DIV_MAX) &&
           (reset_cycles >= RESET_CYCLES_MIN) && (reset_cycles <= RESET_CYCLES_MAX);
  endfunction

endpackage

// File: rtl/cpu65_bus_ctrl_irq_sync.sv
// cpu65_irq_sync: 2-flop synchroniser for an active-low async line; EDGE=1 outputs a falling-edge pulse instead of the level
module cpu65_irq_sync #(
  parameter bit EDGE = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async_n,
  output logic o_out
);

  logic r_s1, r_s2;

  // two-stage metastability filter, cleared to the inactive (high) level
  always_ff @(posedge i_clk)
    if (i_reset) {r_s1, r_s2} <= 2'b11;
    else {r_s2, r_s1} <= {r_s1, i_async_n};

  if (EDGE) begin : g_edge
    logic r_s3;
    // delayed copy of the synchronised level for falling-edge detection
    always_ff @(posedge i_clk)
      r_s3 <= i_reset ? 1'b1 : r_s2;
    assign o_out = r_s3 & ~r_s2;
  end else begin : g_level
    assign o_out = r_s2;
  end

endmodule

// File: rtl/cpu65_bus_ctrl.sv
// cpu65_bus_ctrl: 6502 core to system bus bridge with clock-enable divider, RDY, NMI/IRQ sync and core reset stretcher.
// Optional macro CPU65_BUS_STATS_EN adds o_cycle_cnt / o_stall_cnt performance counters.
module cpu65_bus_ctrl
  import cpu65_pkg::*;
#(
  parameter int ADDR_W       = 13,
  parameter int CLK_DIV      = 3,
  parameter int RESET_CYCLES = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [15:0]       i_core_ab,
  input  logic [7:0]        i_core_do,
  input  logic              i_core_we,
  output logic [7:0]        o_core_di,
  output logic              o_core_clk_en,
  output logic              o_core_rdy,
  output logic              o_core_nmi,
  output logic              o_core_irq,
  output logic              o_core_reset,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [7:0]        o_bus_dout,
  input  logic [7:0]        i_bus_din,
  output logic              o_bus_we,
  output logic              o_bus_re,
  input  logic              i_rdy_req,
  input  logic              i_nmi_n,
  input  logic              i_irq_n,
  output logic              o_stall
`ifdef CPU65_BUS_STATS_EN
  ,
  output logic [31:0]       o_cycle_cnt,
  output logic [31:0]       o_stall_cnt
`endif
);

  localparam logic [3:0] PH_LAST  = 4'(CLK_DIV - 1);
  localparam logic [3:0] PH_LOAD  = 4'(CLK_DIV - 2);
  localparam logic [7:0] RST_LAST = 8'(RESET_CYCLES - 1);

  if (!params_ok(ADDR_W, CLK_DIV, RESET_CYCLES)) begin : g_param_err
    $error("cpu65_bus_ctrl: ADDR_W, CLK_DIV or RESET_CYCLES out of range");
  end

  logic [3:0] r_ph;
  logic [7:0] r_core_di;
  logic       r_rdy_q;
  rst_state_t r_state;
  logic [7:0] r_rst_cnt;
  logic       r_nmi_pend;
  logic       w_ce;
  logic       w_nmi_fall;
  logic       w_irq_s;
  logic       w_vec_fetch;

  cpu65_irq_sync #(.EDGE(1'b1)) u_nmi_sync (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_async_n(i_nmi_n),
    .o_out    (w_nmi_fall)
  );

  cpu65_irq_sync #(.EDGE(1'b0)) u_irq_sync (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_async_n(i_irq_n),
    .o_out    (w_irq_s)
  );

  assign w_ce          = (r_ph == PH_LAST);
  assign o_core_clk_en = w_ce;
  assign o_core_reset  = (r_state == RST_HOLD);
  // RDY only halts reads; a write cycle always completes
  assign o_core_rdy    = ~(r_rdy_q & ~i_core_we);
  assign o_stall       = ~o_core_rdy;
  assign o_core_di     = r_core_di;
  assign o_core_nmi    = r_nmi_pend;
  assign o_core_irq    = ~w_irq_s;
  assign o_bus_addr    = i_core_ab[ADDR_W-1:0];
  assign o_bus_dout    = i_core_do;
  assign o_bus_we      = w_ce & i_core_we & ~o_core_reset;
  assign o_bus_re      = w_ce & ~i_core_we & ~o_core_reset;
  assign w_vec_fetch   = w_ce & (i_core_ab == NMI_VEC_LO) & ~i_core_we & o_core_rdy;

  // phase counter: core_clk_en fires on the last phase of each CPU cycle
  always_ff @(posedge i_clk)
    r_ph <= (i_reset || w_ce) ? 4'd0 : r_ph + 4'd1;

  // capture read data one clk before the core's enable edge
  always_ff @(posedge i_clk)
    if (i_reset) r_core_di <= 8'h00;
    else if (r_ph == PH_LOAD) r_core_di <= i_bus_din;

  // halt request register
  always_ff @(posedge i_clk)
    r_rdy_q <= i_reset ? 1'b0 : i_rdy_req;

  // reset stretcher: hold core in reset for RESET_CYCLES CPU cycles
  always_ff @(posedge i_clk)
    if (i_reset) begin
      r_state   <= RST_HOLD;
      r_rst_cnt <= 8'd0;
    end else if (r_state == RST_HOLD && w_ce) begin
      if (r_rst_cnt == RST_LAST) r_state <= RST_RUN;
      else r_rst_cnt <= r_rst_cnt + 8'd1;
    end

  // NMI latch: edge sets (wins over clear), vector fetch clears, edges during core reset dropped
  always_ff @(posedge i_clk)
    if (i_reset) r_nmi_pend <= 1'b0;
    else if (w_nmi_fall && !o_core_reset) r_nmi_pend <= 1'b1;
    else if (w_vec_fetch) r_nmi_pend <= 1'b0;

`ifdef CPU65_BUS_STATS_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_stall_cnt;

  assign o_cycle_cnt = r_cycle_cnt;
  assign o_stall_cnt = r_stall_cnt;

  // run-time and stall cycle counters, wrapping modulo 2^32
  always_ff @(posedge i_clk)
    if (i_reset) begin
      r_cycle_cnt <= 32'd0;
      r_stall_cnt <= 32'd0;
    end else if (w_ce) begin
      if (!o_core_reset) r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (!o_core_rdy) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_cpu65_bus_ctrl.sv
// tb_cpu65_bus_ctrl: directed self-checking bench for cpu65_bus_ctrl (CLK_DIV=3, RESET_CYCLES=8)
module tb_cpu65_bus_ctrl;

  localparam int CLK_DIV = 3;

  logic clk = 1'b0, rst = 1'b1;
  logic [15:0] core_ab = 16'h0000;
  logic [7:0] core_do = 8'h00, bus_din = 8'h00;
  logic core_we = 1'b0, rdy_req = 1'b0, nmi_n = 1'b1, irq_n = 1'b1;
  logic [7:0] core_di, bus_dout;
  logic ce, core_rdy, core_nmi, core_irq, core_reset, bus_we, bus_re, stall;
  logic [12:0] bus_addr;
  logic [7:0] x_core_di, x_bus_dout;
  logic x_ce, x_core_rdy, x_core_nmi, x_core_irq, x_core_reset, x_bus_we, x_bus_re, x_stall;
  logic [15:0] x_bus_addr;
`ifdef CPU65_BUS_STATS_EN
  logic [31:0] cycle_cnt, stall_cnt, x_cycle_cnt, x_stall_cnt;
`endif
  int pass = 0, total = 0, ph_m = 0;

  cpu65_bus_ctrl #(.ADDR_W(13), .CLK_DIV(CLK_DIV), .RESET_CYCLES(8)) dut (
    .i_clk(clk), .i_reset(rst), .i_core_ab(core_ab), .i_core_do(core_do), .i_core_we(core_we),
    .o_core_di(core_di), .o_core_clk_en(ce), .o_core_rdy(core_rdy), .o_core_nmi(core_nmi),
    .o_core_irq(core_irq), .o_core_reset(core_reset), .o_bus_addr(bus_addr), .o_bus_dout(bus_dout),
    .i_bus_din(bus_din), .o_bus_we(bus_we), .o_bus_re(bus_re), .i_rdy_req(rdy_req),
    .i_nmi_n(nmi_n), .i_irq_n(irq_n), .o_stall(stall)
`ifdef CPU65_BUS_STATS_EN
    , .o_cycle_cnt(cycle_cnt), .o_stall_cnt(stall_cnt)
`endif
  );

  cpu65_bus_ctrl #(.ADDR_W(16), .CLK_DIV(CLK_DIV), .RESET_CYCLES(8)) dut16 (
    .i_clk(clk), .i_reset(rst), .i_core_ab(core_ab), .i_core_do(core_do), .i_core_we(core_we),
    .o_core_di(x_core_di), .o_core_clk_en(x_ce), .o_core_rdy(x_core_rdy), .o_core_nmi(x_core_nmi),
    .o_core_irq(x_core_irq), .o_core_reset(x_core_reset), .o_bus_addr(x_bus_addr), .o_bus_dout(x_bus_dout),
    .i_bus_din(bus_din), .o_bus_we(x_bus_we), .o_bus_re(x_bus_re), .i_rdy_req(rdy_req),
    .i_nmi_n(nmi_n), .i_irq_n(irq_n), .o_stall(x_stall)
`ifdef CPU65_BUS_STATS_EN
    , .o_cycle_cnt(x_cycle_cnt), .o_stall_cnt(x_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // bench-side phase model: 0..CLK_DIV-1, held at 0 in reset
  always @(posedge clk) ph_m <= rst ? 0 : (ph_m == CLK_DIV - 1 ? 0 : ph_m + 1);

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic goto_ph(input int p);
    for (int i = 0; i < CLK_DIV && ph_m != p; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    logic exp_ce, exp_rst, exp_re;
    rst = 1'b1; irq_n = 1'b0; nmi_n = 1'b1; rdy_req = 1'b1; core_we = 1'b0;
    step(3);
    total++; if (ce !== 1'b0) $display("FAIL reset_ce: got %b want 0", ce); else pass++;
    total++; if (core_di !== 8'h00) $display("FAIL reset_core_di: got %h want 00", core_di); else pass++;
    total++; if (core_rdy !== 1'b1) $display("FAIL reset_core_rdy: got %b want 1", core_rdy); else pass++;
    total++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else pass++;
    total++; if (core_nmi !== 1'b0) $display("FAIL reset_core_nmi: got %b want 0", core_nmi); else pass++;
    total++; if (core_irq !== 1'b0) $display("FAIL reset_core_irq: got %b want 0", core_irq); else pass++;
    total++; if (core_reset !== 1'b1) $display("FAIL reset_core_reset: got %b want 1", core_reset); else pass++;
    total++; if (bus_we !== 1'b0) $display("FAIL reset_bus_we: got %b want 0", bus_we); else pass++;
    total++; if (bus_re !== 1'b0) $display("FAIL reset_bus_re: got %b want 0", bus_re); else pass++;
    irq_n = 1'b1; rdy_req = 1'b0;
    step(3);
    rst = 1'b0;
    for (int k = 1; k <= 27; k++) begin
      step();
      exp_ce = (k % 3 == 2);
      exp_rst = (k < 24);
      exp_re = exp_ce && !exp_rst;
      total++; if (ce !== exp_ce) $display("FAIL div_ce k=%0d: got %b want %b", k, ce, exp_ce); else pass++;
      total++; if (core_reset !== exp_rst) $display("FAIL stretch_core_reset k=%0d: got %b want %b", k, core_reset, exp_rst); else pass++;
      total++; if (bus_re !== exp_re) $display("FAIL stretch_bus_re k=%0d: got %b want %b", k, bus_re, exp_re); else pass++;
    end
  endtask

  task automatic test_read;
    goto_ph(0);
    core_we = 1'b0; core_ab = 16'hFF80; bus_din = 8'h5A;
    step();
    bus_din = 8'hA5;
    step();
    total++; if (ce !== 1'b1) $display("FAIL read_ce: got %b want 1", ce); else pass++;
    total++; if (core_di !== 8'hA5) $display("FAIL read_core_di: got %h want a5", core_di); else pass++;
    total++; if (bus_re !== 1'b1) $display("FAIL read_bus_re: got %b want 1", bus_re); else pass++;
    total++; if (bus_we !== 1'b0) $display("FAIL read_bus_we: got %b want 0", bus_we); else pass++;
    total++; if (bus_addr !== 13'h1F80) $display("FAIL read_bus_addr13: got %h want 1f80", bus_addr); else pass++;
    total++; if (x_bus_addr !== 16'hFF80) $display("FAIL read_bus_addr16: got %h want ff80", x_bus_addr); else pass++;
    bus_din = 8'h00;
    step();
    total++; if (bus_re !== 1'b0) $display("FAIL read_re_oneclk: got %b want 0", bus_re); else pass++;
    total++; if (core_di !== 8'hA5) $display("FAIL read_di_hold: got %h want a5", core_di); else pass++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] din_v [3] = '{8'h11, 8'hC3, 8'h7E};
    logic [15:0] ab_v [3] = '{16'h0123, 16'h2FFF, 16'hE000};
    for (int i = 0; i < 3; i++) begin
      goto_ph(1);
      bus_din = din_v[i]; core_ab = ab_v[i]; core_do = ~din_v[i];
      step();
      total++; if (core_di !== din_v[i]) $display("FAIL b2b_core_di[%0d]: got %h want %h", i, core_di, din_v[i]); else pass++;
      total++; if (bus_re !== 1'b1) $display("FAIL b2b_bus_re[%0d]: got %b want 1", i, bus_re); else pass++;
      total++; if (bus_addr !== ab_v[i][12:0]) $display("FAIL b2b_bus_addr[%0d]: got %h want %h", i, bus_addr, ab_v[i][12:0]); else pass++;
      total++; if (bus_dout !== ~din_v[i]) $display("FAIL b2b_bus_dout[%0d]: got %h want %h", i, bus_dout, ~din_v[i]); else pass++;
    end
  endtask

  task automatic test_rdy_write;
    goto_ph(0);
    core_we = 1'b1; core_do = 8'h3C; core_ab = 16'h0002; rdy_req = 1'b1;
    step();
    total++; if (core_rdy !== 1'b1) $display("FAIL wr_rdy_ph1: got %b want 1", core_rdy); else pass++;
    total++; if (stall !== 1'b0) $display("FAIL wr_stall_ph1: got %b want 0", stall); else pass++;
    step();
    total++; if (bus_we !== 1'b1) $display("FAIL wr_bus_we: got %b want 1", bus_we); else pass++;
    total++; if (bus_re !== 1'b0) $display("FAIL wr_bus_re: got %b want 0", bus_re); else pass++;
    total++; if (core_rdy !== 1'b1) $display("FAIL wr_rdy_ce: got %b want 1", core_rdy); else pass++;
    total++; if (bus_dout !== 8'h3C) $display("FAIL wr_bus_dout: got %h want 3c", bus_dout); else pass++;
    step();
    core_we = 1'b0;
    #1;
    total++; if (core_rdy !== 1'b0) $display("FAIL rd_after_wr_rdy: got %b want 0", core_rdy); else pass++;
    total++; if (stall !== 1'b1) $display("FAIL rd_after_wr_stall: got %b want 1", stall); else pass++;
    step(2);
    total++; if (core_rdy !== 1'b0) $display("FAIL halted_rdy_ce: got %b want 0", core_rdy); else pass++;
    total++; if (bus_we !== 1'b0) $display("FAIL halted_bus_we: got %b want 0", bus_we); else pass++;
    rdy_req = 1'b0;
    #1;
    total++; if (core_rdy !== 1'b0) $display("FAIL release_same_clk: got %b want 0", core_rdy); else pass++;
    step();
    total++; if (core_rdy !== 1'b1) $display("FAIL release_next_clk: got %b want 1", core_rdy); else pass++;
    total++; if (stall !== 1'b0) $display("FAIL release_stall: got %b want 0", stall); else pass++;
    rdy_req = 1'b1;
    step();
    total++; if (stall !== 1'b1) $display("FAIL halt_latency: got %b want 1", stall); else pass++;
    rdy_req = 1'b0;
    step();
    total++; if (stall !== 1'b0) $display("FAIL halt_drop: got %b want 0", stall); else pass++;
  endtask

  task automatic test_irq;
    irq_n = 1'b0;
    step();
    total++; if (core_irq !== 1'b0) $display("FAIL irq_lat1: got %b want 0", core_irq); else pass++;
    step();
    total++; if (core_irq !== 1'b1) $display("FAIL irq_lat2: got %b want 1", core_irq); else pass++;
    irq_n = 1'b1;
    step();
    total++; if (core_irq !== 1'b1) $display("FAIL irq_fall1: got %b want 1", core_irq); else pass++;
    step();
    total++; if (core_irq !== 1'b0) $display("FAIL irq_fall2: got %b want 0", core_irq); else pass++;
  endtask

  task automatic test_nmi;
    rdy_req = 1'b0; core_we = 1'b0; core_ab = 16'h0200; nmi_n = 1'b0;
    step(2);
    total++; if (core_nmi !== 1'b0) $display("FAIL nmi_lat2: got %b want 0", core_nmi); else pass++;
    step();
    total++; if (core_nmi !== 1'b1) $display("FAIL nmi_lat3: got %b want 1", core_nmi); else pass++;
    nmi_n = 1'b1;
    step(3);
    nmi_n = 1'b0;
    step(4);
    total++; if (core_nmi !== 1'b1) $display("FAIL nmi_absorb: got %b want 1", core_nmi); else pass++;
    goto_ph(0);
    core_ab = 16'hFFFA;
    step(2);
    total++; if (ce !== 1'b1) $display("FAIL nmi_vec_ce: got %b want 1", ce); else pass++;
    total++; if (core_nmi !== 1'b1) $display("FAIL nmi_before_clear: got %b want 1", core_nmi); else pass++;
    step();
    core_ab = 16'h0200;
    total++; if (core_nmi !== 1'b0) $display("FAIL nmi_clear: got %b want 0", core_nmi); else pass++;
    step(4);
    total++; if (core_nmi !== 1'b0) $display("FAIL nmi_no_queue: got %b want 0", core_nmi); else pass++;
  endtask

  task automatic test_nmi_collision_reset;
    nmi_n = 1'b1;
    step(4);
    nmi_n = 1'b0;
    step(4);
    total++; if (core_nmi !== 1'b1) $display("FAIL coll_pend: got %b want 1", core_nmi); else pass++;
    nmi_n = 1'b1;
    step(3);
    goto_ph(0);
    nmi_n = 1'b0; core_ab = 16'hFFFA; core_we = 1'b0;
    step(2);
    total++; if (ce !== 1'b1) $display("FAIL coll_ce: got %b want 1", ce); else pass++;
    step();
    core_ab = 16'h0200;
    total++; if (core_nmi !== 1'b1) $display("FAIL coll_set_wins: got %b want 1", core_nmi); else pass++;
    rdy_req = 1'b1;
    step();
    total++; if (core_rdy !== 1'b0) $display("FAIL rst_pre_rdy: got %b want 0", core_rdy); else pass++;
    rst = 1'b1;
    step();
    total++; if (core_nmi !== 1'b0) $display("FAIL rst_abort_nmi: got %b want 0", core_nmi); else pass++;
    total++; if (core_rdy !== 1'b1) $display("FAIL rst_abort_rdy: got %b want 1", core_rdy); else pass++;
    total++; if (core_reset !== 1'b1) $display("FAIL rst_abort_core_reset: got %b want 1", core_reset); else pass++;
    total++; if (stall !== 1'b0) $display("FAIL rst_abort_stall: got %b want 0", stall); else pass++;
    step();
    total++; if (core_rdy !== 1'b1) $display("FAIL rst_hold_rdy: got %b want 1", core_rdy); else pass++;
    rdy_req = 1'b0; nmi_n = 1'b1;
    step();
    rst = 1'b0;
    step(3);
    nmi_n = 1'b0;
    step(6);
    total++; if (core_reset !== 1'b1) $display("FAIL nmi_in_reset_core_reset: got %b want 1", core_reset); else pass++;
    total++; if (core_nmi !== 1'b0) $display("FAIL nmi_in_reset_dropped: got %b want 0", core_nmi); else pass++;
    nmi_n = 1'b1;
    step(30);
    total++; if (core_reset !== 1'b0) $display("FAIL post_reset_run: got %b want 0", core_reset); else pass++;
    total++; if (core_nmi !== 1'b0) $display("FAIL post_reset_no_residue: got %b want 0", core_nmi); else pass++;
  endtask

`ifdef CPU65_BUS_STATS_EN
  task automatic test_stats;
    rst = 1'b1; rdy_req = 1'b0; core_we = 1'b0; core_ab = 16'h0200;
    step(2);
    total++; if (cycle_cnt !== 32'd0) $display("FAIL stats_rst_cycle: got %0d want 0", cycle_cnt); else pass++;
    total++; if (stall_cnt !== 32'd0) $display("FAIL stats_rst_stall: got %0d want 0", stall_cnt); else pass++;
    rst = 1'b0;
    step(24);
    for (int i = 0; i < 100; i++) begin
      rdy_req = (i < 10);
      step(3);
    end
    rdy_req = 1'b0;
    total++; if (cycle_cnt !== 32'd100) $display("FAIL stats_cycle: got %0d want 100", cycle_cnt); else pass++;
    total++; if (stall_cnt !== 32'd10) $display("FAIL stats_stall: got %0d want 10", stall_cnt); else pass++;
    force dut.r_cycle_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_cycle_cnt;
    step(3);
    total++; if (cycle_cnt !== 32'd0) $display("FAIL stats_wrap: got %h want 0", cycle_cnt); else pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_back_to_back();
    test_rdy_write();
    test_irq();
    test_nmi();
    test_nmi_collision_reset();
`ifdef CPU65_BUS_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
